// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-word memory port between the core (core_*) and the
//   program loader / DMA port (ldr_*). Each transaction runs
//   IDLE -> ISSUE -> WAIT -> ACK -> IDLE, with a fixed memory read latency.
//
// Ports
//   clk, rst                      clock (rising edge), synchronous active-high reset
//   core_req/we/addr/wdata        core request; held until core_ack
//   core_gnt/ack/rdata            core owns port / completion pulse / read data
//   ldr_req/we/addr/wdata         loader request; held until ldr_ack
//   ldr_gnt/ack/rdata             loader owns port / completion pulse / read data
//   mem_en/we/addr/wdata          memory strobe (one cycle per transaction) + fields
//   mem_rdata                     memory read data, valid MEM_LAT cycles after mem_en
//   busy                          FSM is not in IDLE
//
// Parameters
//   ADDR_W, DATA_W                address and data widths
//   MEM_LAT                       cycles from the mem_en cycle to valid mem_rdata (1..15)
//   FIXED_PRIO                    0 = round-robin on ties, 1 = core always wins a tie
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int MEM_LAT    = 2,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_gnt,
  output logic              core_ack,
  output logic [DATA_W-1:0] core_rdata,

  input  logic              ldr_req,
  input  logic              ldr_we,
  input  logic [ADDR_W-1:0] ldr_addr,
  input  logic [DATA_W-1:0] ldr_wdata,
  output logic              ldr_gnt,
  output logic              ldr_ack,
  output logic [DATA_W-1:0] ldr_rdata,

  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,

  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_ACK   = 2'd3
  } state_t;

  localparam logic [3:0] LAT_CNT = 4'(MEM_LAT);

  state_t     state_reg;
  logic [3:0] cnt_reg;
  logic       last_reg;   // 0 = core was granted last, 1 = loader
  logic       owner_reg;  // 0 = core owns the port, 1 = loader
  logic       we_reg;     // latched write flag of the current transaction
  logic       pick_ldr;   // arbitration result, only meaningful in IDLE

  // Loader wins when it is the only requester, or on a round-robin tie
  // where the core was served last. With fixed priority the core takes ties.
  always_comb begin
    pick_ldr = 1'b0;
    if (ldr_req) begin
      if (!core_req)
        pick_ldr = 1'b1;
      else if (FIXED_PRIO == 0)
        pick_ldr = !last_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= 4'd0;
      last_reg   <= 1'b1;   // pretend loader went last so the core wins the first tie
      owner_reg  <= 1'b0;
      we_reg     <= 1'b0;
      core_gnt   <= 1'b0;
      core_ack   <= 1'b0;
      core_rdata <= '0;
      ldr_gnt    <= 1'b0;
      ldr_ack    <= 1'b0;
      ldr_rdata  <= '0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      busy       <= 1'b0;
    end else begin
      // Pulsed outputs default low; each is raised for exactly one state.
      core_ack <= 1'b0;
      ldr_ack  <= 1'b0;
      mem_en   <= 1'b0;
      mem_we   <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (core_req || ldr_req) begin
            owner_reg <= pick_ldr;
            last_reg  <= pick_ldr;
            we_reg    <= pick_ldr ? ldr_we : core_we;
            mem_addr  <= pick_ldr ? ldr_addr : core_addr;
            mem_wdata <= pick_ldr ? ldr_wdata : core_wdata;
            // Strobe is registered here so it is visible during ISSUE.
            mem_en    <= 1'b1;
            mem_we    <= pick_ldr ? ldr_we : core_we;
            core_gnt  <= !pick_ldr;
            ldr_gnt   <= pick_ldr;
            busy      <= 1'b1;
            state_reg <= S_ISSUE;
          end
        end

        S_ISSUE: begin
          cnt_reg   <= LAT_CNT;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          // cnt==1 is the last WAIT cycle, which is exactly MEM_LAT cycles
          // after the strobe: the memory data is valid now.
          if (cnt_reg == 4'd1) begin
            if (!we_reg) begin
              if (owner_reg)
                ldr_rdata <= mem_rdata;
              else
                core_rdata <= mem_rdata;
            end
            core_ack  <= !owner_reg;
            ldr_ack   <= owner_reg;
            state_reg <= S_ACK;
          end
        end

        S_ACK: begin
          core_gnt  <= 1'b0;
          ldr_gnt   <= 1'b0;
          busy      <= 1'b0;
          state_reg <= S_IDLE;
        end

        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule
